uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with a buffered valid/ready input. It adds a programmable baud divisor, configurable frame width up to MAX_WIDTH, even/odd/no parity, and 1 or 2 stop bits. It sits between the core-side interface logic and the TX pin. Frames are transmitted back-to-back from the internal FIFO without idle gaps.

Parameters:
MAX_WIDTH, 16, maximum data bits per frame; data port width.
DIV_WIDTH, 16, width of baud divisor.
FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
LVL_W, $clog2(FIFO_DEPTH+1), width of fifo_level (derived).
WID_W, $clog2(MAX_WIDTH+1), width of width port (derived).

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  synchronous, active-low reset.
divisor  in  DIV_WIDTH  bit period = divisor+1 clocks.
parity  in  2  [1]=parity enable, [0]=odd (1) / even (0).
width  in  WID_W  data bits per frame; 0 or >MAX_WIDTH means MAX_WIDTH.
stop2  in  1  1 = two stop bits, 0 = one.
in_valid  in  1  producer has a word.
in_data  in  MAX_WIDTH  word; LSB sent first, bits at index ≥ width ignored.
in_ready  out  1  FIFO can accept.
busy  out  1  frame in progress or FIFO non-empty.
fifo_level  out  LVL_W  occupied entries.
out  out  1  serial TX line, idle high.

Behaviour:
- Reset (reset==0 sampled at a rising edge) sets: out=1, in_ready=1, busy=0, fifo_level=0, FSM=IDLE, baud counter=0, FIFO emptied. This applies mid-frame as well: the line returns high at that edge and the partial frame is dropped.
- Handshake: a word is accepted on an edge with in_valid & in_ready. in_ready = (fifo_level != FIFO_DEPTH). A push and a pop on the same edge leave the level unchanged. No push occurs while full, even if a pop happens that edge.
- Configuration (divisor, parity, width, stop2) is latched at frame start. Changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when the FIFO is non-empty, pop the head into the shift register, latch config, and go to START. out=0 from this edge; the baud counter is loaded with the latched divisor.
- Each state holds out for divisor+1 clocks. The counter decrements each clock, and the state advances on the edge where it is 0. divisor=0 gives one bit per clock.
- START → DATA: out=bit0.
- DATA: shift right and accumulate p ^= bit. After eff_width bits, go to PARITY if parity[1], else STOP.
- PARITY: out = p ^ parity[0], i.e. the parity bit makes the total count of ones even when parity[0]=0 and odd when parity[0]=1.
- STOP: out=1 for one or two bit periods. At the end, if the FIFO is non-empty, pop and enter START directly (out=0 on that edge, no idle gap). Otherwise go to IDLE.
- Latency: word accepted at edge E into an empty FIFO with FSM in IDLE: out falls at edge E+1.
- Frame length in bit periods = 1 + eff_width + parity[1] + 1 + stop2.
- Bit counter is WID_W bits wide and never wraps inside a frame. The FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- busy = (FSM != IDLE) | (fifo_level != 0).

Decomposition:
- Shared package/define file holds: FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), parity-field bit positions (PAR_EN=1, PAR_ODD=0).
- One sub-module: uart_fifo. Synchronous FIFO with push/pop/full/empty/level; reusable by the future RX block.
- Serializer FSM stays in uart_tx_fifo.

Test Plan:
1. divisor=0, width=8, parity=00, stop2=0; push 8'hA5 → out sequence 0,1,0,1,0,0,1,0,1,1, one clock each; busy drops after the stop bit.
2. divisor=3, width=7, parity=11 (odd); push 7'h03 → each bit held 4 clocks; parity bit=1; frame lasts 40 clocks.
3. width=16, parity=10 (even), stop2=1; push 16'hFFFF → 16 ones, parity 0, two stop periods.
4. Push FIFO_DEPTH+1 words back-to-back, divisor=1 → in_ready low after 4 accepts while first frame in flight (with FIFO_DEPTH=4); frames contiguous (stop bit directly followed by start bit); all 5 words transmitted in order.
5. reset asserted for one edge during DATA of a frame with 3 queued words → out=1, fifo_level=0, busy=0 at that edge; the next push transmits normally.
6. width=0 and width=20 with MAX_WIDTH=16 → both send 16 data bits; changing divisor mid-frame from 1 to 5 → current frame keeps 2-clock bits, next frame uses 6.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmitter and its FIFO.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

  // Bit positions inside the two-bit parity configuration field.
  localparam int PAR_EN  = 1;
  localparam int PAR_ODD = 0;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int MAX_WIDTH = 16
);
  logic                 in_valid;
  logic [MAX_WIDTH-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with occupancy level; shared by UART TX and RX.
module uart_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [LVL_W-1:0] level_q;
  logic             doPush;
  logic             doPop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign popData = mem[rdPtr_q];
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr_q] <= pushData;
  end

  // Pointers wrap naturally; level tracks push/pop, unchanged when both happen.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a small word FIFO; frames go out back-to-back.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int MAX_WIDTH  = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1),
  parameter int WID_W      = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity,
  input  logic [WID_W-1:0]     width,
  input  logic                 stop2,
  uart_tx_fifo_if.slave        inBus,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 out
);

  txState_e             state_q;
  logic                 out_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [WID_W-1:0]     bitCnt_q;
  logic [WID_W-1:0]     effWidth_q;
  logic                 parEn_q;
  logic                 parOdd_q;
  logic                 stop2_q;
  logic                 stopCnt_q;
  logic                 parAcc_q;
  logic [MAX_WIDTH-1:0] shift_q;

  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [MAX_WIDTH-1:0] fifoHead;
  logic                 startFrame;

  // Out-of-range or zero width requests fall back to the full data width.
  function automatic logic [WID_W-1:0] effWidth(input logic [WID_W-1:0] w);
    if (w == '0 || w > WID_W'(MAX_WIDTH)) return WID_W'(MAX_WIDTH);
    return w;
  endfunction

  uart_fifo #(
    .WIDTH (MAX_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inBus.in_valid),
    .pushData (inBus.in_data),
    .pop      (startFrame),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifo_level)
  );

  // A new frame begins from idle, or straight after the final stop period.
  assign startFrame = ~fifoEmpty &
                      ((state_q == IDLE) |
                       ((state_q == STOP) & (cnt_q == '0) & ~stopCnt_q));

  assign inBus.in_ready = ~fifoFull;
  assign busy           = (state_q != IDLE) | (fifo_level != '0);
  assign out            = out_q;

  // Serializer: each state holds the line for div+1 clocks, config latched per frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      out_q      <= 1'b1;
      cnt_q      <= '0;
      div_q      <= '0;
      bitCnt_q   <= '0;
      effWidth_q <= WID_W'(MAX_WIDTH);
      parEn_q    <= 1'b0;
      parOdd_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stopCnt_q  <= 1'b0;
      parAcc_q   <= 1'b0;
      shift_q    <= '0;
    end else if (startFrame) begin
      state_q    <= START;
      out_q      <= 1'b0;
      cnt_q      <= divisor;
      div_q      <= divisor;
      shift_q    <= fifoHead;
      effWidth_q <= effWidth(width);
      parEn_q    <= parity[PAR_EN];
      parOdd_q   <= parity[PAR_ODD];
      stop2_q    <= stop2;
    end else if (state_q != IDLE && cnt_q != '0) begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end else begin
      case (state_q)
        IDLE: begin
          out_q <= 1'b1;
        end
        START: begin
          state_q  <= DATA;
          cnt_q    <= div_q;
          out_q    <= shift_q[0];
          parAcc_q <= shift_q[0];
          shift_q  <= shift_q >> 1;
          bitCnt_q <= WID_W'(1);
        end
        DATA: begin
          cnt_q <= div_q;
          if (bitCnt_q == effWidth_q) begin
            if (parEn_q) begin
              state_q <= PARITY;
              out_q   <= parAcc_q ^ parOdd_q;
            end else begin
              state_q   <= STOP;
              out_q     <= 1'b1;
              stopCnt_q <= stop2_q;
            end
          end else begin
            out_q    <= shift_q[0];
            parAcc_q <= parAcc_q ^ shift_q[0];
            shift_q  <= shift_q >> 1;
            bitCnt_q <= bitCnt_q + WID_W'(1);
          end
        end
        PARITY: begin
          state_q   <= STOP;
          cnt_q     <= div_q;
          out_q     <= 1'b1;
          stopCnt_q <= stop2_q;
        end
        STOP: begin
          if (stopCnt_q) begin
            stopCnt_q <= 1'b0;
            cnt_q     <= div_q;
          end else begin
            state_q <= IDLE;
            out_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a line-sample model.
module tb_uart_tx_fifo;

  localparam int MAX_WIDTH  = 16;
  localparam int DIV_WIDTH  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = 3;
  localparam int WID_W      = 5;

  logic                 clock = 1'b0;
  logic                 rstN;
  logic [DIV_WIDTH-1:0] cfgDiv;
  logic [1:0]           cfgPar;
  logic [WID_W-1:0]     cfgWidth;
  logic                 cfgStop2;
  logic                 busy;
  logic [LVL_W-1:0]     level;
  logic                 txOut;

  int errors = 0;
  int checks = 0;

  // Reference model: queued words and the per-clock line samples still to be sent.
  logic [MAX_WIDTH-1:0] mFifo[$];
  bit                   lineQ[$];
  logic                 expOut;
  logic                 expBusy;
  logic                 accepted;
  logic                 sawFull;

  uart_tx_fifo_if #(.MAX_WIDTH(MAX_WIDTH)) txBus ();

  uart_tx_fifo #(
    .MAX_WIDTH  (MAX_WIDTH),
    .DIV_WIDTH  (DIV_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LVL_W),
    .WID_W      (WID_W)
  ) dut (
    .clock      (clock),
    .reset      (rstN),
    .divisor    (cfgDiv),
    .parity     (cfgPar),
    .width      (cfgWidth),
    .stop2      (cfgStop2),
    .inBus      (txBus),
    .busy       (busy),
    .fifo_level (level),
    .out        (txOut)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expand one word into line samples using the configuration seen at frame start.
  task automatic buildFrame(input logic [MAX_WIDTH-1:0] w);
    int ew;
    int ones;
    bit bits[$];
    ew   = (cfgWidth == 0 || cfgWidth > MAX_WIDTH) ? MAX_WIDTH : int'(cfgWidth);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < ew; i++) begin
      bits.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (cfgPar[1]) bits.push_back(bit'(ones % 2) ^ cfgPar[0]);
    bits.push_back(1'b1);
    if (cfgStop2) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r <= int'(cfgDiv); r++) lineQ.push_back(bits[k]);
    end
  endtask

  task automatic modelStep(input logic v, input logic [MAX_WIDTH-1:0] d, input logic r);
    logic [MAX_WIDTH-1:0] w;
    if (!r) begin
      mFifo.delete();
      lineQ.delete();
      expOut   = 1'b1;
      expBusy  = 1'b0;
      accepted = 1'b0;
    end else begin
      accepted = v && (mFifo.size() < FIFO_DEPTH);
      if (lineQ.size() == 0 && mFifo.size() != 0) begin
        w = mFifo.pop_front();
        buildFrame(w);
      end
      if (accepted) mFifo.push_back(d);
      if (lineQ.size() != 0) begin
        expOut  = lineQ.pop_front();
        expBusy = 1'b1;
      end else begin
        expOut  = 1'b1;
        expBusy = (mFifo.size() != 0);
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic applyStimulus(input logic v, input logic [MAX_WIDTH-1:0] d, input logic r);
    txBus.in_valid = v;
    txBus.in_data  = d;
    rstN           = r;
    @(posedge clock);
    modelStep(v, d, r);
    #1;
    checkOutput("out",   32'(txOut), 32'(expOut));
    checkOutput("busy",  32'(busy), 32'(expBusy));
    checkOutput("level", 32'(level), 32'(mFifo.size()));
    checkOutput("ready", 32'(txBus.in_ready), 32'(mFifo.size() < FIFO_DEPTH));
    if (!txBus.in_ready) sawFull = 1'b1;
    txBus.in_valid = 1'b0;
    rstN           = 1'b1;
  endtask

  task automatic pushWord(input logic [MAX_WIDTH-1:0] w);
    int tries;
    tries = 0;
    do begin
      applyStimulus(1'b1, w, 1'b1);
      tries++;
    end while (!accepted && tries < 500);
    if (!accepted) checkOutput("pushTimeout", 32'(tries), 32'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((lineQ.size() != 0 || mFifo.size() != 0) && n < 3000) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    applyStimulus(1'b0, '0, 1'b1);
    if (n >= 3000) checkOutput("drainTimeout", 32'(n), 32'(0));
  endtask

  task automatic setCfg(input int dv, input logic [1:0] p, input int w, input logic s2);
    cfgDiv   = DIV_WIDTH'(dv);
    cfgPar   = p;
    cfgWidth = WID_W'(w);
    cfgStop2 = s2;
  endtask

  initial begin
    logic [9:0] cap;
    int         len;
    logic [MAX_WIDTH-1:0] words [5];

    txBus.in_valid = 1'b0;
    txBus.in_data  = '0;
    rstN           = 1'b0;
    sawFull        = 1'b0;
    setCfg(0, 2'b00, 8, 1'b0);

    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rstOut", 32'(txOut), 32'(1));
    applyStimulus(1'b0, '0, 1'b1);

    // 8N1 at one clock per bit: exact line sequence for 0xA5.
    setCfg(0, 2'b00, 8, 1'b0);
    applyStimulus(1'b1, 16'h00A5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      cap[i] = txOut;
    end
    checkOutput("t1Seq", 32'(cap), 32'(10'b1101001010));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1BusyLow", 32'(busy), 32'(0));

    // 7O1 at four clocks per bit: frame occupies 40 clocks.
    setCfg(3, 2'b11, 7, 1'b0);
    pushWord(16'h0003);
    len = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (!busy) break;
      len++;
    end
    checkOutput("t2Len", 32'(len), 32'(40));

    // 16 data bits, even parity, two stop bits.
    setCfg(1, 2'b10, 16, 1'b1);
    pushWord(16'hFFFF);
    drain();

    // Overfill: FIFO fills while the first frame is on the line.
    setCfg(1, 2'b00, 8, 1'b0);
    sawFull = 1'b0;
    words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    for (int k = 0; k < 5; k++) pushWord(words[k]);
    checkOutput("t4Full", 32'(sawFull), 32'(1));
    drain();

    // Reset in the middle of a data phase with words queued.
    setCfg(1, 2'b00, 8, 1'b0);
    for (int k = 0; k < 4; k++) pushWord(16'h00C0 + 16'(k));
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t5Out", 32'(txOut), 32'(1));
    checkOutput("t5Level", 32'(level), 32'(0));
    pushWord(16'h005A);
    drain();

    // Width 0 and 20 both mean 16; divisor change only affects the next frame.
    setCfg(1, 2'b00, 0, 1'b0);
    pushWord(16'h8001);
    drain();
    setCfg(1, 2'b00, 20, 1'b0);
    pushWord(16'h7FFE);
    drain();
    setCfg(1, 2'b00, 8, 1'b0);
    pushWord(16'h0096);
    pushWord(16'h0069);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    cfgDiv = 16'd5;
    drain();

    // Random traffic with occasional reconfiguration and resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 59) == 0)
        setCfg($urandom_range(0, 2), 2'($urandom_range(0, 3)),
               $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      applyStimulus(1'($urandom_range(0, 2) == 0), 16'($urandom),
                    1'($urandom_range(0, 399) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
